// File: rtl/t07_pkg.sv
// Shared encodings for the Simon module: stage state codes, raw button codes
// and colour codes, plus a helper that picks one colour out of the sequence bus.
package t07_pkg;

  localparam logic [3:0] SIMON_D1 = 4'd0;
  localparam logic [3:0] SIMON_I1 = 4'd1;
  localparam logic [3:0] SIMON_D2 = 4'd2;
  localparam logic [3:0] SIMON_I2 = 4'd3;
  localparam logic [3:0] SIMON_D3 = 4'd4;
  localparam logic [3:0] SIMON_I3 = 4'd5;
  localparam logic [3:0] SIMON_D4 = 4'd6;
  localparam logic [3:0] SIMON_I4 = 4'd7;
  localparam logic [3:0] SIMON_D5 = 4'd8;
  localparam logic [3:0] SIMON_I5 = 4'd9;

  localparam logic [2:0] SIMON_LAST_STAGE = 3'd4;

  // One-hot raw button bus order: {BACK,LEFT,DOWN,RIGHT,UP,SELECT}
  localparam logic [5:0] BTN_NO_PRESS = 6'b000000;
  localparam logic [5:0] BTN_SELECT   = 6'b000001;
  localparam logic [5:0] BTN_UP       = 6'b000010;
  localparam logic [5:0] BTN_RIGHT    = 6'b000100;
  localparam logic [5:0] BTN_DOWN     = 6'b001000;
  localparam logic [5:0] BTN_LEFT     = 6'b010000;
  localparam logic [5:0] BTN_BACK     = 6'b100000;

  typedef enum logic [1:0] {
    COL_UP    = 2'd0,
    COL_RIGHT = 2'd1,
    COL_DOWN  = 2'd2,
    COL_LEFT  = 2'd3
  } colour_t;

  function automatic logic [1:0] seq_colour(input logic [9:0] seq, input logic [2:0] idx);
    logic [1:0] col;
    case (idx)
      3'd0:    col = seq[1:0];
      3'd1:    col = seq[3:2];
      3'd2:    col = seq[5:4];
      3'd3:    col = seq[7:6];
      default: col = seq[9:8];
    endcase
    return col;
  endfunction

endpackage

// File: rtl/t07_button_sync_edge.sv
// Two-flop synchroniser for the raw button bus plus a previous-value register;
// flags a new single-colour press and reports which colour it was.
module t07_button_sync_edge
  import t07_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic [5:0] unsync_button,
  output logic       press_valid,
  output logic [1:0] press_colour
);

  logic [5:0] btn_p0;
  logic [5:0] btn_p1;
  logic [5:0] btn_p2;
  logic       is_colour;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      btn_p0 <= BTN_NO_PRESS;
      btn_p1 <= BTN_NO_PRESS;
      btn_p2 <= BTN_NO_PRESS;
    end else begin
      btn_p0 <= unsync_button;
      btn_p1 <= btn_p0;
      btn_p2 <= btn_p1;
    end
  end

  // SELECT, BACK and chords never decode to a colour
  always_comb begin
    is_colour    = 1'b1;
    press_colour = COL_UP;
    case (btn_p1)
      BTN_UP:    press_colour = COL_UP;
      BTN_RIGHT: press_colour = COL_RIGHT;
      BTN_DOWN:  press_colour = COL_DOWN;
      BTN_LEFT:  press_colour = COL_LEFT;
      default:   is_colour = 1'b0;
    endcase
  end

  assign press_valid = is_colour && (btn_p2 == BTN_NO_PRESS);

endmodule

// File: rtl/t07_simon_input_checker.sv
// Simon stage controller: paces display states on s_strobe, then checks the
// player's presses against the colour sequence, issuing strikes and the clear flag.
module t07_simon_input_checker
  import t07_pkg::*;
#(
  parameter int TIMEOUT = 10
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       enable,
  input  logic       s_strobe,
  input  logic [5:0] unsync_button,
  input  logic [9:0] simon_sequence_bus,
  output logic [3:0] simon_state,
  output logic       simon_cleared,
  output logic       simon_strike
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic            press_valid;
  logic [1:0]      press_colour;
  logic [3:0]      state;
  logic            cleared;
  logic            strike;
  logic [3:0]      disp_cnt;
  logic [2:0]      in_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [2:0]      stage;
  logic            in_input;
  logic            disp_last;
  logic            to_last;
  logic            colour_ok;

  t07_button_sync_edge u_sync (
    .clk          (clk),
    .nrst         (nrst),
    .unsync_button(unsync_button),
    .press_valid  (press_valid),
    .press_colour (press_colour)
  );

  assign stage     = state[3:1];
  assign in_input  = state[0];
  // Display lasts 3 wait + (stage+1) light + 1 off ticks
  assign disp_last = (disp_cnt == ({1'b0, stage} + 4'd4));
  assign to_last   = (to_cnt == TO_W'(TIMEOUT - 1));
  assign colour_ok = (press_colour == seq_colour(simon_sequence_bus, in_cnt));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= SIMON_D1;
      cleared  <= 1'b0;
      strike   <= 1'b0;
      disp_cnt <= '0;
      in_cnt   <= '0;
      to_cnt   <= '0;
    end else begin
      strike <= 1'b0;
      if (!enable) begin
        state    <= SIMON_D1;
        cleared  <= 1'b0;
        disp_cnt <= '0;
        in_cnt   <= '0;
        to_cnt   <= '0;
      end else if (!cleared) begin
        if (!in_input) begin
          if (s_strobe) begin
            if (disp_last) begin
              state    <= state + 4'd1;
              disp_cnt <= '0;
              in_cnt   <= '0;
              to_cnt   <= '0;
            end else begin
              disp_cnt <= disp_cnt + 4'd1;
            end
          end
        end else if (press_valid) begin
          if (!colour_ok) begin
            strike   <= 1'b1;
            state    <= state - 4'd1;
            disp_cnt <= '0;
            in_cnt   <= '0;
            to_cnt   <= '0;
          end else if (in_cnt < stage) begin
            in_cnt <= in_cnt + 3'd1;
            to_cnt <= '0;
          end else if (stage < SIMON_LAST_STAGE) begin
            state    <= state + 4'd1;
            disp_cnt <= '0;
            in_cnt   <= '0;
            to_cnt   <= '0;
          end else begin
            cleared  <= 1'b1;
            disp_cnt <= '0;
            in_cnt   <= '0;
            to_cnt   <= '0;
          end
        end else if (s_strobe) begin
          if (to_last) begin
            strike   <= 1'b1;
            state    <= state - 4'd1;
            disp_cnt <= '0;
            in_cnt   <= '0;
            to_cnt   <= '0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
      end
    end
  end

  assign simon_state   = state;
  assign simon_cleared = cleared;
  assign simon_strike  = strike;

endmodule

// File: tb/tb_t07_simon_input_checker.sv
// Directed bench for the Simon input checker: a step table walks the game,
// then hand-written sequences cover same-cycle press/strobe and async reset.
module tb_t07_simon_input_checker;
  import t07_pkg::*;

  logic       clk;
  logic       nrst;
  logic       enable;
  logic       s_strobe;
  logic [5:0] unsync_button;
  logic [9:0] simon_sequence_bus;
  logic [3:0] simon_state;
  logic       simon_cleared;
  logic       simon_strike;

  t07_simon_input_checker #(.TIMEOUT(10)) dut (
    .clk               (clk),
    .nrst              (nrst),
    .enable            (enable),
    .s_strobe          (s_strobe),
    .unsync_button     (unsync_button),
    .simon_sequence_bus(simon_sequence_bus),
    .simon_state       (simon_state),
    .simon_cleared     (simon_cleared),
    .simon_strike      (simon_strike)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int strike_total = 0;
  int strike_run = 0;
  int strike_run_max = 0;

  always @(negedge clk) begin
    if (simon_strike === 1'b1) begin
      strike_total <= strike_total + 1;
      strike_run   <= strike_run + 1;
      if (strike_run + 1 > strike_run_max) strike_run_max <= strike_run + 1;
    end else begin
      strike_run <= 0;
    end
  end

  typedef struct {
    string      name;
    bit         en_low;
    logic [5:0] btn;
    int         hold;
    int         strobes;
    logic [3:0] exp_state;
    logic       exp_cleared;
    int         exp_strikes;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string nm, bit en_low, logic [5:0] btn, int hold, int strobes,
                              logic [3:0] st, logic cl, int sk);
    vec_t v;
    v.name = nm; v.en_low = en_low; v.btn = btn; v.hold = hold; v.strobes = strobes;
    v.exp_state = st; v.exp_cleared = cl; v.exp_strikes = sk;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_strobes(input int n);
    repeat (n) begin
      s_strobe = 1'b1;
      cyc(1);
      s_strobe = 1'b0;
      cyc(1);
    end
  endtask

  task automatic do_press(input logic [5:0] btn, input int hold);
    unsync_button = btn;
    cyc(hold);
    unsync_button = BTN_NO_PRESS;
    cyc(4);
  endtask

  task automatic do_en_low();
    enable = 1'b0;
    cyc(2);
    enable = 1'b1;
    cyc(1);
  endtask

  initial begin
    int base;
    nrst = 1'b0;
    enable = 1'b1;
    s_strobe = 1'b0;
    unsync_button = BTN_NO_PRESS;
    simon_sequence_bus = 10'b11_10_01_00_11;  // LEFT, UP, RIGHT, DOWN, LEFT

    // Full walk to clear
    add("d1_to_i1",    0, 0,          4, 5,  4'd1, 0, 0);
    add("i1_left",     0, BTN_LEFT,   4, 0,  4'd2, 0, 0);
    add("d2_to_i2",    0, 0,          4, 6,  4'd3, 0, 0);
    add("i2_left",     0, BTN_LEFT,   4, 0,  4'd3, 0, 0);
    add("i2_up",       0, BTN_UP,     4, 0,  4'd4, 0, 0);
    add("d3_to_i3",    0, 0,          4, 7,  4'd5, 0, 0);
    add("i3_left",     0, BTN_LEFT,   4, 0,  4'd5, 0, 0);
    add("i3_up",       0, BTN_UP,     4, 0,  4'd5, 0, 0);
    add("i3_right",    0, BTN_RIGHT,  4, 0,  4'd6, 0, 0);
    add("d4_to_i4",    0, 0,          4, 8,  4'd7, 0, 0);
    add("i4_left",     0, BTN_LEFT,   4, 0,  4'd7, 0, 0);
    add("i4_up",       0, BTN_UP,     4, 0,  4'd7, 0, 0);
    add("i4_right",    0, BTN_RIGHT,  4, 0,  4'd7, 0, 0);
    add("i4_down",     0, BTN_DOWN,   4, 0,  4'd8, 0, 0);
    add("d5_to_i5",    0, 0,          4, 9,  4'd9, 0, 0);
    add("i5_left",     0, BTN_LEFT,   4, 0,  4'd9, 0, 0);
    add("i5_up",       0, BTN_UP,     4, 0,  4'd9, 0, 0);
    add("i5_right",    0, BTN_RIGHT,  4, 0,  4'd9, 0, 0);
    add("i5_down",     0, BTN_DOWN,   4, 0,  4'd9, 0, 0);
    add("i5_left_clr", 0, BTN_LEFT,   4, 0,  4'd9, 1, 0);
    add("clr_press",   0, BTN_UP,     4, 0,  4'd9, 1, 0);
    add("clr_strobes", 0, 0,          4, 20, 4'd9, 1, 0);
    add("clr_abort",   1, 0,          4, 0,  4'd0, 0, 0);
    // Wrong press replays the stage with in_cnt back to 0
    add("w_i1",        0, 0,          4, 5,  4'd1, 0, 0);
    add("w_left",      0, BTN_LEFT,   4, 0,  4'd2, 0, 0);
    add("w_i2",        0, 0,          4, 6,  4'd3, 0, 0);
    add("w_bad_up",    0, BTN_UP,     4, 0,  4'd2, 0, 1);
    add("w_i2_again",  0, 0,          4, 6,  4'd3, 0, 0);
    add("w_left2",     0, BTN_LEFT,   4, 0,  4'd3, 0, 0);
    add("w_up2",       0, BTN_UP,     4, 0,  4'd4, 0, 0);
    // Filtering
    add("f_i1",        1, 0,          4, 5,  4'd1, 0, 0);
    add("f_select",    0, BTN_SELECT, 4, 0,  4'd1, 0, 0);
    add("f_back",      0, BTN_BACK,   4, 0,  4'd1, 0, 0);
    add("f_chord",     0, 6'b001010,  4, 0,  4'd1, 0, 0);
    add("f_d1_press",  1, BTN_LEFT,   4, 0,  4'd0, 0, 0);
    add("f_d1_i1",     0, 0,          4, 5,  4'd1, 0, 0);
    add("f_left",      0, BTN_LEFT,   4, 0,  4'd2, 0, 0);
    add("f_i2",        0, 0,          4, 6,  4'd3, 0, 0);
    add("f_hold20",    0, BTN_LEFT,   20, 0, 4'd3, 0, 0);
    add("f_after_hold",0, BTN_UP,     4, 0,  4'd4, 0, 0);
    // Timeout, and a matching press clears to_cnt
    add("t_i1",        1, 0,          4, 5,  4'd1, 0, 0);
    add("t_nine",      0, 0,          4, 9,  4'd1, 0, 0);
    add("t_tenth",     0, 0,          4, 1,  4'd0, 0, 1);
    add("t2_i1",       0, 0,          4, 5,  4'd1, 0, 0);
    add("t2_left",     0, BTN_LEFT,   4, 0,  4'd2, 0, 0);
    add("t2_i2",       0, 0,          4, 6,  4'd3, 0, 0);
    add("t2_nine",     0, 0,          4, 9,  4'd3, 0, 0);
    add("t2_left",     0, BTN_LEFT,   4, 0,  4'd3, 0, 0);
    add("t2_nine_b",   0, 0,          4, 9,  4'd3, 0, 0);
    add("t2_tenth",    0, 0,          4, 1,  4'd2, 0, 1);
    // Abort from I4
    add("a_i1",        1, 0,          4, 5,  4'd1, 0, 0);
    add("a_left",      0, BTN_LEFT,   4, 0,  4'd2, 0, 0);
    add("a_i2",        0, 0,          4, 6,  4'd3, 0, 0);
    add("a_left2",     0, BTN_LEFT,   4, 0,  4'd3, 0, 0);
    add("a_up",        0, BTN_UP,     4, 0,  4'd4, 0, 0);
    add("a_i3",        0, 0,          4, 7,  4'd5, 0, 0);
    add("a_l3",        0, BTN_LEFT,   4, 0,  4'd5, 0, 0);
    add("a_u3",        0, BTN_UP,     4, 0,  4'd5, 0, 0);
    add("a_r3",        0, BTN_RIGHT,  4, 0,  4'd6, 0, 0);
    add("a_i4",        0, 0,          4, 8,  4'd7, 0, 0);
    add("a_abort",     1, 0,          4, 0,  4'd0, 0, 0);

    // Reset state
    cyc(3);
    check("rst_state",   int'(simon_state), 0);
    check("rst_cleared", int'(simon_cleared), 0);
    check("rst_strike",  int'(simon_strike), 0);
    nrst = 1'b1;
    cyc(2);

    foreach (vecs[i]) begin
      base = strike_total;
      if (vecs[i].en_low) do_en_low();
      if (vecs[i].btn != BTN_NO_PRESS) do_press(vecs[i].btn, vecs[i].hold);
      do_strobes(vecs[i].strobes);
      cyc(1);
      check({vecs[i].name, "_state"},   int'(simon_state),   int'(vecs[i].exp_state));
      check({vecs[i].name, "_cleared"}, int'(simon_cleared), int'(vecs[i].exp_cleared));
      check({vecs[i].name, "_strikes"}, strike_total - base, vecs[i].exp_strikes);
    end

    // Press lands in the same cycle as the 10th strobe: press wins, no strike
    do_en_low();
    do_strobes(5);
    check("same_i1", int'(simon_state), 1);
    do_strobes(9);
    base = strike_total;
    unsync_button = BTN_LEFT;
    cyc(2);
    s_strobe = 1'b1;
    cyc(1);
    s_strobe = 1'b0;
    unsync_button = BTN_NO_PRESS;
    cyc(4);
    check("same_state",   int'(simon_state), 2);
    check("same_strikes", strike_total - base, 0);

    // Async reset in the middle of D3 acts without a clock edge
    do_press(BTN_LEFT, 4);
    do_press(BTN_UP, 4);
    do_strobes(6);
    do_press(BTN_LEFT, 4);
    do_press(BTN_UP, 4);
    check("pre_rst_d3", int'(simon_state), 4);
    do_strobes(3);
    #2;
    nrst = 1'b0;
    #1;
    check("async_state",   int'(simon_state), 0);
    check("async_cleared", int'(simon_cleared), 0);
    @(negedge clk);
    nrst = 1'b1;
    cyc(1);
    do_strobes(4);
    check("post_rst_d1", int'(simon_state), 0);
    do_strobes(1);
    check("post_rst_i1", int'(simon_state), 1);

    check("strike_width", strike_run_max, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
